// File: rtl/issue_select_wakeup_if.sv
// Slot-side bundle between the issue slots and the select/wakeup block.
// The slave side is the selector. The master side is the slots and FU control.
interface issue_select_wakeup_if #(
  parameter int NUM_SLOTS = 8,
  parameter int PREG_W    = 7
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0]        io_slot_request;
  logic [NUM_SLOTS*PREG_W-1:0] io_slot_pdst;
  logic [NUM_SLOTS-1:0]        io_slot_ldst_val;
  logic [NUM_SLOTS*3-1:0]      io_slot_lat;
  logic                        io_fu_ready;
  logic                        io_kill;
  logic [NUM_SLOTS-1:0]        io_slot_grant;
  logic                        io_iss_valid;
  logic [IDX_W-1:0]            io_iss_slot_idx;
  logic                        io_wakeup_ports_0_valid;
  logic [PREG_W-1:0]           io_wakeup_ports_0_bits_pdst;
  logic                        io_wakeup_ports_1_valid;
  logic [PREG_W-1:0]           io_wakeup_ports_1_bits_pdst;

  modport master (
    output io_slot_request, io_slot_pdst, io_slot_ldst_val, io_slot_lat,
           io_fu_ready, io_kill,
    input  io_slot_grant, io_iss_valid, io_iss_slot_idx,
           io_wakeup_ports_0_valid, io_wakeup_ports_0_bits_pdst,
           io_wakeup_ports_1_valid, io_wakeup_ports_1_bits_pdst
  );

  modport slave (
    input  io_slot_request, io_slot_pdst, io_slot_ldst_val, io_slot_lat,
           io_fu_ready, io_kill,
    output io_slot_grant, io_iss_valid, io_iss_slot_idx,
           io_wakeup_ports_0_valid, io_wakeup_ports_0_bits_pdst,
           io_wakeup_ports_1_valid, io_wakeup_ports_1_bits_pdst
  );
endinterface

// File: rtl/issue_select_wakeup.sv
// Lowest-index issue select with latency-timed wakeup broadcast.
// Port 0 carries single-cycle wakeups. Port 1 is fed by a writeback reservation pipe.
module issue_select_wakeup_elig #(
  parameter int MAX_LAT = 4
) (
  input  logic                 req_i,
  input  logic                 ldst_i,
  input  logic [2:0]           lat_i,
  input  logic [MAX_LAT+1:3]   pv_i,
  output logic                 elig_o,
  output logic [2:0]           lat_o
);
  logic busy;

  always_comb begin
    lat_o = lat_i;
    if (lat_i == 3'd0)             lat_o = 3'd1;
    else if (int'(lat_i) > MAX_LAT) lat_o = 3'(MAX_LAT);
    // pipe[L+1] shifts into pipe[L] this edge, so it must be free to insert at L
    busy = 1'b0;
    for (int k = 2; k <= MAX_LAT; k++)
      if (int'(lat_o) == k) busy = pv_i[k+1];
    elig_o = req_i & (~ldst_i | ~busy);
  end
endmodule

module issue_select_wakeup #(
  parameter int NUM_SLOTS = 8,
  parameter int PREG_W    = 7,
  parameter int MAX_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  issue_select_wakeup_if.slave  io
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  logic [MAX_LAT:1]              pv_q, pv_d;
  logic [MAX_LAT:1][PREG_W-1:0]  pp_q, pp_d;
  logic [MAX_LAT+1:3]            pv_hi;
  logic [NUM_SLOTS-1:0]          elig;
  logic [NUM_SLOTS-1:0][2:0]     lat_c;

  logic                 iss_v_q, iss_v_d;
  logic [IDX_W-1:0]     iss_idx_q, iss_idx_d;
  logic                 p0v_q, p0v_d;
  logic [PREG_W-1:0]    p0pdst_q, p0pdst_d;

  logic [NUM_SLOTS-1:0] gnt;
  logic                 found;
  logic [IDX_W-1:0]     sel_idx;
  logic [2:0]           sel_lat;
  logic [PREG_W-1:0]    sel_pdst;
  logic                 sel_ldst;

  for (genvar k = 3; k <= MAX_LAT + 1; k++) begin : g_hi
    if (k <= MAX_LAT) begin : g_v
      assign pv_hi[k] = pv_q[k];
    end else begin : g_e
      assign pv_hi[k] = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    issue_select_wakeup_elig #(.MAX_LAT(MAX_LAT)) u_elig (
      .req_i  (io.io_slot_request[i]),
      .ldst_i (io.io_slot_ldst_val[i]),
      .lat_i  (io.io_slot_lat[i*3 +: 3]),
      .pv_i   (pv_hi),
      .elig_o (elig[i]),
      .lat_o  (lat_c[i])
    );
  end

  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    sel_idx  = '0;
    sel_lat  = 3'd1;
    sel_pdst = '0;
    sel_ldst = 1'b0;
    if (reset && io.io_fu_ready && !io.io_kill) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (elig[i] && !found) begin
          found    = 1'b1;
          gnt[i]   = 1'b1;
          sel_idx  = IDX_W'(i);
          sel_lat  = lat_c[i];
          sel_pdst = io.io_slot_pdst[i*PREG_W +: PREG_W];
          sel_ldst = io.io_slot_ldst_val[i];
        end
      end
    end
  end

  always_comb begin
    pv_d = '0;
    pp_d = '0;
    for (int k = 1; k < MAX_LAT; k++) begin
      pv_d[k] = pv_q[k+1];
      pp_d[k] = pp_q[k+1];
    end
    if (found && sel_ldst) begin
      for (int k = 2; k <= MAX_LAT; k++) begin
        if (int'(sel_lat) == k) begin
          pv_d[k] = 1'b1;
          pp_d[k] = sel_pdst;
        end
      end
    end
    if (io.io_kill) begin
      pv_d = '0;
      pp_d = '0;
    end
    // kill already suppresses the grant, so these fall to zero on their own
    iss_v_d   = found;
    iss_idx_d = sel_idx;
    p0v_d     = found && sel_ldst && (sel_lat == 3'd1);
    p0pdst_d  = p0v_d ? sel_pdst : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_q      <= '0;
      pp_q      <= '0;
      iss_v_q   <= 1'b0;
      iss_idx_q <= '0;
      p0v_q     <= 1'b0;
      p0pdst_q  <= '0;
    end else begin
      pv_q      <= pv_d;
      pp_q      <= pp_d;
      iss_v_q   <= iss_v_d;
      iss_idx_q <= iss_idx_d;
      p0v_q     <= p0v_d;
      p0pdst_q  <= p0pdst_d;
    end
  end

  assign io.io_slot_grant               = gnt;
  assign io.io_iss_valid                = iss_v_q;
  assign io.io_iss_slot_idx             = iss_idx_q;
  assign io.io_wakeup_ports_0_valid     = p0v_q;
  assign io.io_wakeup_ports_0_bits_pdst = p0pdst_q;
  assign io.io_wakeup_ports_1_valid     = pv_q[1];
  assign io.io_wakeup_ports_1_bits_pdst = pv_q[1] ? pp_q[1] : '0;
endmodule

// File: tb/tb_issue_select_wakeup.sv
// Directed bench for issue_select_wakeup: select priority, latency-timed wakeups,
// port-1 reservation, kill, fu_ready stall and async reset.
module tb_issue_select_wakeup;
  localparam int NS = 8;
  localparam int PW = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  issue_select_wakeup_if #(.NUM_SLOTS(NS), .PREG_W(PW)) bus ();

  issue_select_wakeup #(.NUM_SLOTS(NS), .PREG_W(PW), .MAX_LAT(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [PW-1:0] pd, input logic ld, input logic [2:0] lt);
    bus.io_slot_pdst[i*PW +: PW] = pd;
    bus.io_slot_ldst_val[i]      = ld;
    bus.io_slot_lat[i*3 +: 3]    = lt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_p0(input string tag, input logic v, input logic [PW-1:0] pd);
    chk({tag, "_p0v"}, 32'(bus.io_wakeup_ports_0_valid), 32'(v));
    chk({tag, "_p0pdst"}, 32'(bus.io_wakeup_ports_0_bits_pdst), 32'(pd));
  endtask

  task automatic chk_p1(input string tag, input logic v, input logic [PW-1:0] pd);
    chk({tag, "_p1v"}, 32'(bus.io_wakeup_ports_1_valid), 32'(v));
    chk({tag, "_p1pdst"}, 32'(bus.io_wakeup_ports_1_bits_pdst), 32'(pd));
  endtask

  initial begin
    rst_n                = 1'b0;
    bus.io_slot_request  = '0;
    bus.io_slot_pdst     = '0;
    bus.io_slot_ldst_val = '1;
    bus.io_slot_lat      = '0;
    bus.io_fu_ready      = 1'b1;
    bus.io_kill          = 1'b0;
    for (int i = 0; i < NS; i++) set_slot(i, 7'h00, 1'b1, 3'd1);

    // reset: grant forced off even with every slot requesting
    bus.io_slot_request = 8'hFF;
    #2;
    chk("rst_grant", 32'(bus.io_slot_grant), 32'h0);
    chk("rst_iss", 32'(bus.io_iss_valid), 32'h0);
    chk("rst_idx", 32'(bus.io_iss_slot_idx), 32'h0);
    chk_p0("rst", 1'b0, 7'h00);
    chk_p1("rst", 1'b0, 7'h00);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.io_slot_request = 8'h00;

    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_grant", 32'(bus.io_slot_grant), 32'h0);
      chk("idle_p0v", 32'(bus.io_wakeup_ports_0_valid), 32'h0);
      chk("idle_p1v", 32'(bus.io_wakeup_ports_1_valid), 32'h0);
    end

    // lowest of two lat-1 requesters wins, wakes on port 0 next cycle
    set_slot(2, 7'h15, 1'b1, 3'd1);
    set_slot(3, 7'h16, 1'b1, 3'd1);
    bus.io_slot_request = 8'h0C;
    #1;
    chk("t2_grant", 32'(bus.io_slot_grant), 32'h04);
    tick();
    bus.io_slot_request = 8'h00;
    chk("t2_iss", 32'(bus.io_iss_valid), 32'h1);
    chk("t2_idx", 32'(bus.io_iss_slot_idx), 32'h2);
    chk_p0("t2", 1'b1, 7'h15);
    chk_p1("t2", 1'b0, 7'h00);
    tick();
    chk_p0("t2_clr", 1'b0, 7'h00);

    // port-1 reservation blocks slot1, slot3 skips ahead
    set_slot(0, 7'h20, 1'b1, 3'd3);
    bus.io_slot_request = 8'h01;
    #1;
    chk("t3_g0", 32'(bus.io_slot_grant), 32'h01);
    tick();
    set_slot(1, 7'h21, 1'b1, 3'd2);
    set_slot(3, 7'h23, 1'b1, 3'd1);
    bus.io_slot_request = 8'h0A;
    #1;
    chk("t3_g1", 32'(bus.io_slot_grant), 32'h08);
    tick();
    chk_p0("t3_T2", 1'b1, 7'h23);
    chk_p1("t3_T2", 1'b0, 7'h00);
    bus.io_slot_request = 8'h02;
    #1;
    chk("t3_g2", 32'(bus.io_slot_grant), 32'h02);
    tick();
    bus.io_slot_request = 8'h00;
    chk_p1("t3_T3", 1'b1, 7'h20);
    chk_p0("t3_T3", 1'b0, 7'h00);
    tick();
    chk_p1("t3_T4", 1'b1, 7'h21);
    tick();
    chk_p1("t3_T5", 1'b0, 7'h00);

    // lat-3 slot0 blocked by pending lat-4 entry; no-dest slot2 issues anyway
    set_slot(0, 7'h40, 1'b1, 3'd4);
    bus.io_slot_request = 8'h01;
    #1;
    chk("t4_g0", 32'(bus.io_slot_grant), 32'h01);
    tick();
    set_slot(0, 7'h41, 1'b1, 3'd3);
    set_slot(2, 7'h42, 1'b0, 3'd4);
    bus.io_slot_request = 8'h05;
    #1;
    chk("t4_g1", 32'(bus.io_slot_grant), 32'h04);
    tick();
    bus.io_slot_request = 8'h00;
    chk("t4_iss", 32'(bus.io_iss_valid), 32'h1);
    chk("t4_idx", 32'(bus.io_iss_slot_idx), 32'h2);
    chk_p0("t4_A2", 1'b0, 7'h00);
    tick();
    tick();
    chk_p1("t4_A4", 1'b1, 7'h40);
    tick();
    chk_p1("t4_A5", 1'b0, 7'h00);
    chk_p0("t4_A5", 1'b0, 7'h00);

    // latency 0 behaves as 1
    set_slot(4, 7'h50, 1'b1, 3'd0);
    bus.io_slot_request = 8'h10;
    #1;
    chk("lat0_grant", 32'(bus.io_slot_grant), 32'h10);
    tick();
    bus.io_slot_request = 8'h00;
    chk_p0("lat0", 1'b1, 7'h50);
    chk_p1("lat0", 1'b0, 7'h00);
    tick();

    // kill squashes an in-flight lat-3 wakeup
    set_slot(1, 7'h31, 1'b1, 3'd3);
    bus.io_slot_request = 8'h02;
    #1;
    chk("kill_g0", 32'(bus.io_slot_grant), 32'h02);
    tick();
    chk("kill_iss_T1", 32'(bus.io_iss_valid), 32'h1);
    bus.io_kill = 1'b1;
    bus.io_slot_request = 8'hFF;
    #1;
    chk("kill_grant", 32'(bus.io_slot_grant), 32'h0);
    tick();
    bus.io_kill = 1'b0;
    bus.io_slot_request = 8'h00;
    chk("kill_iss_T2", 32'(bus.io_iss_valid), 32'h0);
    chk_p0("kill_T2", 1'b0, 7'h00);
    chk_p1("kill_T2", 1'b0, 7'h00);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("kill_p1_late", 32'(bus.io_wakeup_ports_1_valid), 32'h0);
    end

    // lat 7 clamps to 4; fu_ready stall does not stop the pipe
    set_slot(5, 7'h57, 1'b1, 3'd7);
    bus.io_slot_request = 8'h20;
    #1;
    chk("stall_g0", 32'(bus.io_slot_grant), 32'h20);
    tick();
    bus.io_fu_ready = 1'b0;
    bus.io_slot_request = 8'hFF;
    #1;
    chk("stall_g1", 32'(bus.io_slot_grant), 32'h0);
    tick();
    chk("stall_iss", 32'(bus.io_iss_valid), 32'h0);
    chk("stall_g2", 32'(bus.io_slot_grant), 32'h0);
    chk_p1("stall_B2", 1'b0, 7'h00);
    tick();
    chk("stall_g3", 32'(bus.io_slot_grant), 32'h0);
    tick();
    bus.io_fu_ready = 1'b1;
    bus.io_slot_request = 8'h00;
    chk_p1("stall_B4", 1'b1, 7'h57);
    chk("stall_iss4", 32'(bus.io_iss_valid), 32'h0);
    tick();

    // async reset drops an in-flight wakeup
    set_slot(0, 7'h60, 1'b1, 3'd4);
    bus.io_slot_request = 8'h01;
    #1;
    chk("arst_grant", 32'(bus.io_slot_grant), 32'h01);
    tick();
    bus.io_slot_request = 8'h00;
    chk("arst_iss_pre", 32'(bus.io_iss_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_iss", 32'(bus.io_iss_valid), 32'h0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("arst_p1", 32'(bus.io_wakeup_ports_1_valid), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
